// File: rtl/demux4x2_if.sv
// demux4x2_if: lane inputs, acks, ring outputs and ejection port.
// slave = router exit stage, master = surrounding fabric / bench.
interface demux4x2_if #(
  parameter int CW = 32
);
  logic [CW-1:0] port0_ci;
  logic [CW-1:0] port1_ci;
  logic [CW-1:0] port2_ci;
  logic [CW-1:0] port3_ci;
  logic [3:0]    in_ack;
  logic [CW-1:0] port0_co;
  logic [CW-1:0] port1_co;
  logic [CW-1:0] ej_data;
  logic          ej_valid;
  logic          ej_ready;

  modport slave (
    input  port0_ci,
    input  port1_ci,
    input  port2_ci,
    input  port3_ci,
    input  ej_ready,
    output in_ack,
    output port0_co,
    output port1_co,
    output ej_data,
    output ej_valid
  );

  modport master (
    output port0_ci,
    output port1_ci,
    output port2_ci,
    output port3_ci,
    output ej_ready,
    input  in_ack,
    input  port0_co,
    input  port1_co,
    input  ej_data,
    input  ej_valid
  );
endinterface

// File: rtl/demux4x2.sv
// demux4x2: hring exit stage. Ejects local flits into a FIFO, arbitrates
// transit flits onto two registered ring outputs (round-robin).
// Ports: clk, rst (async active-low), bus (demux4x2_if.slave):
//   port0..3_ci lanes in, in_ack (comb), port0/1_co (registered),
//   ej_data/ej_valid/ej_ready ejection FIFO head.
// Option: DEMUX4X2_STATS_EN adds stall_cnt[15:0] (saturating stall count).
// CW must match the control-word width used by the ring (`control_w).
module demux4x2 #(
  parameter int CW       = 32,
  parameter int DEST_W   = 4,
  parameter int DEST_LSB = 0,
  parameter int NODE_ID  = 0,
  parameter int EJ_DEPTH = 4
) (
  input logic        clk,
  input logic        rst,
`ifdef DEMUX4X2_STATS_EN
  demux4x2_if.slave  bus,
  output logic [15:0] stall_cnt
`else
  demux4x2_if.slave  bus
`endif
);

  localparam int CNT_W = $clog2(EJ_DEPTH + 1);
  localparam int PTR_W = $clog2(EJ_DEPTH);

  logic [CW-1:0]    lane [4];
  logic [3:0]       valid;
  logic [3:0]       is_loc;
  logic [3:0]       is_tr;

  logic [1:0]       rr_q, rr_d;
  logic [1:0]       ej_ptr_q, ej_ptr_d;
  logic [CW-1:0]    port0_q, port0_d;
  logic [CW-1:0]    port1_q, port1_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [CW-1:0]    mem [EJ_DEPTH];

  logic             g0_v, g1_v;
  logic [1:0]       g0, g1;
  logic             ej_v;
  logic [1:0]       ej_w;
  logic [1:0]       idx;
  logic [1:0]       eidx;
  logic [3:0]       ack;
  logic             full;
  logic             push, pop;
  logic [CW-1:0]    push_word;

  always_comb begin
    lane[0] = bus.port0_ci;
    lane[1] = bus.port1_ci;
    lane[2] = bus.port2_ci;
    lane[3] = bus.port3_ci;
  end

  always_comb begin
    valid  = '0;
    is_loc = '0;
    is_tr  = '0;
    for (int i = 0; i < 4; i++) begin
      valid[i]  = lane[i][CW-1];
      is_loc[i] = valid[i] &&
        (lane[i][DEST_LSB +: DEST_W] == DEST_W'(NODE_ID));
      is_tr[i]  = valid[i] && !is_loc[i];
    end
  end

  // Transit: first two transit lanes found from rr_q.
  always_comb begin
    g0_v = 1'b0;
    g1_v = 1'b0;
    g0   = '0;
    g1   = '0;
    idx  = '0;
    for (int k = 0; k < 4; k++) begin
      idx = rr_q + 2'(k);
      if (is_tr[idx]) begin
        if (!g0_v) begin
          g0_v = 1'b1;
          g0   = idx;
        end else if (!g1_v) begin
          g1_v = 1'b1;
          g1   = idx;
        end
      end
    end
  end

  // Ejection: fullness is judged at cycle start, no pop bypass.
  assign full = (cnt_q == CNT_W'(EJ_DEPTH));

  always_comb begin
    ej_v = 1'b0;
    ej_w = '0;
    eidx = '0;
    if (!full) begin
      for (int k = 0; k < 4; k++) begin
        eidx = ej_ptr_q + 2'(k);
        if (is_loc[eidx] && !ej_v) begin
          ej_v = 1'b1;
          ej_w = eidx;
        end
      end
    end
  end

  always_comb begin
    ack = '0;
    if (g0_v) ack[g0] = 1'b1;
    if (g1_v) ack[g1] = 1'b1;
    if (ej_v) ack[ej_w] = 1'b1;
  end

  always_comb begin
    port0_d   = g0_v ? lane[g0] : '0;
    port1_d   = g1_v ? lane[g1] : '0;
    rr_d      = rr_q;
    ej_ptr_d  = ej_ptr_q;
    if (g1_v)      rr_d = g1 + 2'd1;
    else if (g0_v) rr_d = g0 + 2'd1;
    if (ej_v) ej_ptr_d = ej_w + 2'd1;
  end

  always_comb begin
    push      = ej_v;
    pop       = (cnt_q != '0) && bus.ej_ready;
    push_word = lane[ej_w];
    cnt_d     = cnt_q + CNT_W'(push) - CNT_W'(pop);
    wr_d      = push ? wr_q + PTR_W'(1) : wr_q;
    rd_d      = pop  ? rd_q + PTR_W'(1) : rd_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_q     <= '0;
      ej_ptr_q <= '0;
      port0_q  <= '0;
      port1_q  <= '0;
      cnt_q    <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
    end else begin
      rr_q     <= rr_d;
      ej_ptr_q <= ej_ptr_d;
      port0_q  <= port0_d;
      port1_q  <= port1_d;
      cnt_q    <= cnt_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
    end
  end

  // Storage needs no reset; cnt_q alone marks entries live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_q] <= push_word;
  end

  assign bus.in_ack   = ack;
  assign bus.port0_co = port0_q;
  assign bus.port1_co = port1_q;
  assign bus.ej_data  = mem[rd_q];
  assign bus.ej_valid = (cnt_q != '0);

`ifdef DEMUX4X2_STATS_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (|(valid & ~ack) && stall_q != 16'hFFFF)
      stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_q <= '0;
    else      stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_demux4x2.sv
// tb_demux4x2: directed vector table plus hand sequences for
// FIFO-full blocking, drain order and async reset.
module tb_demux4x2;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;

  demux4x2_if #(.CW(32)) bus ();

`ifdef DEMUX4X2_STATS_EN
  logic [15:0] stall_cnt;
  demux4x2 dut (
    .clk(clk), .rst(rst), .bus(bus), .stall_cnt(stall_cnt)
  );
`else
  demux4x2 dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] l0, l1, l2, l3;
    logic        ejr;
    logic [3:0]  ack;
    logic [31:0] p0, p1;
    logic        ejv;
    logic [31:0] ejd;
    logic [1:0]  rr;
  } vec_t;

  vec_t tv [7];

  function automatic logic [31:0] mk(input int d, input int t);
    mk = {1'b1, 19'd0, 8'(t), 4'(d)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic lanes(input logic [31:0] a, b, c, d);
    bus.port0_ci = a;
    bus.port1_ci = b;
    bus.port2_ci = c;
    bus.port3_ci = d;
  endtask

  logic [31:0] L [5];
  logic [31:0] D0, D1, D2, D3;

  initial begin
    lanes('0, '0, '0, '0);
    bus.ej_ready = 1'b1;

    tv[0] = '{mk(1,8'h10), mk(2,8'h11), mk(3,8'h12), mk(5,8'h13),
              1'b1, 4'b0011, mk(1,8'h10), mk(2,8'h11), 1'b0, '0, 2'd2};
    tv[1] = '{'0, '0, mk(3,8'h12), mk(5,8'h13),
              1'b1, 4'b1100, mk(3,8'h12), mk(5,8'h13), 1'b0, '0, 2'd0};
    tv[2] = '{'0, '0, '0, mk(6,8'h20),
              1'b1, 4'b1000, mk(6,8'h20), '0, 1'b0, '0, 2'd0};
    tv[3] = '{'0, '0, '0, '0,
              1'b1, 4'b0000, '0, '0, 1'b0, '0, 2'd0};
    tv[4] = '{mk(0,8'h30), mk(7,8'h31), mk(0,8'h32), mk(9,8'h33),
              1'b1, 4'b1011, mk(7,8'h31), mk(9,8'h33), 1'b1,
              mk(0,8'h30), 2'd0};
    tv[5] = '{'0, '0, mk(0,8'h32), '0,
              1'b1, 4'b0100, '0, '0, 1'b1, mk(0,8'h32), 2'd0};
    tv[6] = '{'0, '0, '0, '0,
              1'b1, 4'b0000, '0, '0, 1'b0, '0, 2'd0};

    // reset state
    #3;
    chk("rst_p0", bus.port0_co, '0);
    chk("rst_p1", bus.port1_co, '0);
    chk("rst_ejv", 32'(bus.ej_valid), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    foreach (tv[i]) begin
      @(negedge clk);
      lanes(tv[i].l0, tv[i].l1, tv[i].l2, tv[i].l3);
      bus.ej_ready = tv[i].ejr;
      #1;
      chk($sformatf("v%0d_ack", i), 32'(bus.in_ack), 32'(tv[i].ack));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_p0", i), bus.port0_co, tv[i].p0);
      chk($sformatf("v%0d_p1", i), bus.port1_co, tv[i].p1);
      chk($sformatf("v%0d_ejv", i), 32'(bus.ej_valid), 32'(tv[i].ejv));
      if (tv[i].ejv)
        chk($sformatf("v%0d_ejd", i), bus.ej_data, tv[i].ejd);
      chk($sformatf("v%0d_rr", i), 32'(dut.rr_q), 32'(tv[i].rr));
    end

    // fresh start so ejection order begins at lane 0
    @(negedge clk);
    lanes('0, '0, '0, '0);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 4; i++) L[i] = mk(0, 8'h40 + i);
    L[4] = mk(0, 8'h50);

    @(negedge clk);
    bus.ej_ready = 1'b0;
    lanes(L[0], L[1], L[2], L[3]);
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("fill%0d_ack", c), 32'(bus.in_ack), 32'(1 << c));
      @(posedge clk);
      #1;
      if (c == 0) bus.port0_ci = '0;
      if (c == 1) bus.port1_ci = '0;
      if (c == 2) bus.port2_ci = '0;
      if (c == 3) bus.port3_ci = '0;
    end
    @(negedge clk);
    chk("full_cnt", 32'(dut.cnt_q), 32'd4);
    chk("full_ejd", bus.ej_data, L[0]);
    bus.port0_ci = L[4];
    #1;
    chk("full_ack", 32'(bus.in_ack), 32'd0);
    @(negedge clk);
    bus.ej_ready = 1'b1;
    #1;
    chk("full_rdy_ack", 32'(bus.in_ack), 32'd0);
    @(negedge clk);
    bus.ej_ready = 1'b0;
    chk("after_pop_cnt", 32'(dut.cnt_q), 32'd3);
    #1;
    chk("late_push_ack", 32'(bus.in_ack), 32'd1);
    @(posedge clk);
    #1;
    bus.port0_ci = '0;
    chk("refill_cnt", 32'(dut.cnt_q), 32'd4);
    for (int k = 1; k < 5; k++) begin
      @(negedge clk);
      bus.ej_ready = 1'b1;
      chk($sformatf("drain%0d_ejv", k), 32'(bus.ej_valid), 32'd1);
      chk($sformatf("drain%0d_ejd", k), bus.ej_data, L[k]);
    end
    @(negedge clk);
    chk("drained_ejv", 32'(bus.ej_valid), 32'd0);

    // mid-stream reset with two FIFO entries and a live output
    bus.ej_ready = 1'b0;
    D0 = mk(8, 8'h63);
    D1 = mk(0, 8'h60);
    D2 = mk(4, 8'h61);
    D3 = mk(0, 8'h62);
    lanes('0, D1, D2, '0);
    #1;
    chk("mix_a_ack", 32'(bus.in_ack), 32'b0110);
    @(negedge clk);
    lanes(D0, '0, '0, D3);
    #1;
    chk("mix_b_ack", 32'(bus.in_ack), 32'b1001);
    @(posedge clk);
    #1;
    lanes('0, '0, '0, '0);
    chk("mix_b_p0", bus.port0_co, D0);
    chk("mix_b_cnt", 32'(dut.cnt_q), 32'd2);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_p0", bus.port0_co, '0);
    chk("arst_p1", bus.port1_co, '0);
    chk("arst_ejv", 32'(bus.ej_valid), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_rr", 32'(dut.rr_q), 32'd0);
    chk("arst_ejp", 32'(dut.ej_ptr_q), 32'd0);
`ifdef DEMUX4X2_STATS_EN
    chk("arst_stall", 32'(stall_cnt), 32'd0);
`endif
    lanes(mk(1,8'h70), mk(2,8'h71), mk(3,8'h72), mk(4,8'h73));
    #1;
    chk("post_rst_ack", 32'(bus.in_ack), 32'b0011);
    @(posedge clk);
    #1;
    chk("post_rst_p0", bus.port0_co, mk(1,8'h70));
    chk("post_rst_p1", bus.port1_co, mk(2,8'h71));

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
